// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone master bridge: cycle-type and burst-type
// encodings, the bridge state enum, and a counter-width helper.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    BUS,
    RSP
  } wb_state_e;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_master_bridge.sv
// Wishbone B4 master bridge: turns a command/write-data/response stream
// interface into incrementing Wishbone bursts. Each beat is terminated by
// ack_i, err_i or rty_i (in that priority), or by a timeout. A retry
// re-issues the same beat after a one-cycle strobe gap. An error or a
// timeout ends the whole burst.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  // command
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_adr,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [3:0]  cmd_len,
  // write data
  input  logic        wdat_valid,
  output logic        wdat_ready,
  input  logic [31:0] wdat,
  // per-beat response
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_last,
  // Wishbone master
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [2:0]  cti_o,
  output logic [1:0]  bte_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam int TMO_W = cnt_width(TIMEOUT);
  localparam int RTY_W = cnt_width(MAX_RETRY);

  wb_state_e        state;
  wb_state_e        state_next;

  logic [3:0]       len_q;
  logic [3:0]       beat_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             stb_gap;

  logic             term_ack;
  logic             term_err;
  logic             do_retry;

  // State register; reset abandons any burst in flight without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus decoding of how the current bus beat terminates.
  always_comb begin
    state_next = state;
    term_ack   = 1'b0;
    term_err   = 1'b0;
    do_retry   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_next = cmd_we ? WDATA : BUS;
        end
      end
      WDATA: begin
        if (wdat_valid) begin
          state_next = BUS;
        end
      end
      BUS: begin
        if (!stb_gap) begin
          if (ack_i) begin
            term_ack = 1'b1;
          end else if (err_i) begin
            term_err = 1'b1;
          end else if (rty_i) begin
            if (retry_cnt < RTY_W'(MAX_RETRY)) begin
              do_retry = 1'b1;
            end else begin
              term_err = 1'b1;
            end
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            term_err = 1'b1;
          end
          if (term_ack || term_err) begin
            state_next = RSP;
          end
        end
      end
      RSP: begin
        if (rsp_ready) begin
          if (rsp_last) begin
            state_next = IDLE;
          end else begin
            state_next = we_o ? WDATA : BUS;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs and burst cycle type follow directly from the state.
  always_comb begin
    cmd_ready  = (state == IDLE) && !rst;
    wdat_ready = (state == WDATA);
    stb_o      = (state == BUS) && !stb_gap;
    rsp_valid  = (state == RSP);
    bte_o      = BTE_LINEAR;
    if (len_q == 4'd0) begin
      cti_o = CTI_CLASSIC;
    end else if (beat_cnt == len_q) begin
      cti_o = CTI_EOB;
    end else begin
      cti_o = CTI_INCR;
    end
  end

  // Beat, retry and timeout counters plus the one-cycle strobe gap after a retry.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      beat_cnt  <= '0;
      retry_cnt <= '0;
      tmo_cnt   <= '0;
      stb_gap   <= 1'b0;
    end else begin
      stb_gap <= do_retry;

      if (state != BUS || stb_gap || do_retry) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (state == IDLE && cmd_valid) begin
        len_q     <= cmd_len;
        beat_cnt  <= '0;
        retry_cnt <= '0;
      end else if (do_retry) begin
        retry_cnt <= retry_cnt + 1'b1;
      end else if (state == RSP && rsp_ready && !rsp_last) begin
        beat_cnt  <= beat_cnt + 1'b1;
        retry_cnt <= '0;
      end
    end
  end

  // Wishbone address/data/control registers; cyc_o spans the whole burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_o <= '0;
      dat_o <= '0;
      sel_o <= '0;
      we_o  <= 1'b0;
      cyc_o <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        adr_o <= {cmd_adr[31:2], 2'b00};
        sel_o <= cmd_sel;
        we_o  <= cmd_we;
      end

      if (state == WDATA && wdat_valid) begin
        dat_o <= wdat;
      end

      if (state != BUS && state_next == BUS) begin
        cyc_o <= 1'b1;
      end else if (term_err) begin
        cyc_o <= 1'b0;
      end else if (state == RSP && rsp_ready && rsp_last) begin
        cyc_o <= 1'b0;
      end

      if (state == RSP && rsp_ready && !rsp_last) begin
        adr_o <= adr_o + 32'd4;
      end
    end
  end

  // Response registers captured when a beat terminates.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_dat  <= '0;
      rsp_err  <= 1'b0;
      rsp_last <= 1'b0;
    end else begin
      if (term_ack) begin
        rsp_dat  <= we_o ? 32'd0 : dat_i;
        rsp_err  <= 1'b0;
        rsp_last <= (beat_cnt == len_q);
      end else if (term_err) begin
        rsp_dat  <= 32'd0;
        rsp_err  <= 1'b1;
        rsp_last <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed testbench for wb_master_bridge. The Wishbone slave is played by
// the test tasks. Inputs change and outputs are sampled on the falling clock
// edge, so every step is exactly one DUT cycle.
module tb_wb_master_bridge;

  localparam int TB_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_adr;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [3:0]  cmd_len;
  logic        wdat_valid;
  logic        wdat_ready;
  logic [31:0] wdat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_last;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        cyc_o;
  logic        stb_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;

  int compared   = 0;
  int mismatched = 0;

  wb_master_bridge #(
    .TIMEOUT   (TB_TIMEOUT),
    .MAX_RETRY (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_adr    (cmd_adr),
    .cmd_we     (cmd_we),
    .cmd_sel    (cmd_sel),
    .cmd_len    (cmd_len),
    .wdat_valid (wdat_valid),
    .wdat_ready (wdat_ready),
    .wdat       (wdat),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_err    (rsp_err),
    .rsp_last   (rsp_last),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .sel_o      (sel_o),
    .we_o       (we_o),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .cti_o      (cti_o),
    .bte_o      (bte_o),
    .dat_i      (dat_i),
    .ack_i      (ack_i),
    .err_i      (err_i),
    .rty_i      (rty_i)
  );

  always #5 clk = ~clk;

  // Presents one command for a single cycle; returns on the falling edge
  // after it was taken, with the DUT in its first WDATA or BUS cycle.
  task automatic issue_cmd(input logic [31:0] adr, input logic we,
                           input logic [3:0] sel, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_adr   = adr;
    cmd_we    = we;
    cmd_sel   = sel;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_cmd_ready: got %0b want 0", cmd_ready);
    end
    compared++;
    if ({cyc_o, stb_o, we_o, rsp_valid, rsp_err, rsp_last, wdat_ready} !== 7'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: cyc=%0b stb=%0b we=%0b rv=%0b re=%0b rl=%0b wr=%0b want all 0",
               cyc_o, stb_o, we_o, rsp_valid, rsp_err, rsp_last, wdat_ready);
    end
    compared++;
    if (adr_o !== 32'd0 || dat_o !== 32'd0 || rsp_dat !== 32'd0 || sel_o !== 4'd0 ||
        cti_o !== 3'b000 || bte_o !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_data: adr=%h dat=%h rsp=%h sel=%h cti=%b bte=%b want zeros",
               adr_o, dat_o, rsp_dat, sel_o, cti_o, bte_o);
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_release_cmd_ready: got %0b want 1", cmd_ready);
    end
  endtask

  task automatic test_single_read();
    issue_cmd(32'h0000_0010, 1'b0, 4'hF, 4'd0);
    compared++;
    if (cyc_o !== 1'b1 || stb_o !== 1'b1 || we_o !== 1'b0 || adr_o !== 32'h10 ||
        cti_o !== 3'b000 || cmd_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL read_bus: cyc=%0b stb=%0b we=%0b adr=%h cti=%b crdy=%0b want 1 1 0 00000010 000 0",
               cyc_o, stb_o, we_o, adr_o, cti_o, cmd_ready);
    end
    @(negedge clk);
    @(negedge clk);
    ack_i = 1'b1;
    dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    ack_i = 1'b0;
    dat_i = 32'd0;
    compared++;
    if (rsp_valid !== 1'b1 || rsp_dat !== 32'hDEAD_BEEF || rsp_last !== 1'b1 ||
        rsp_err !== 1'b0 || stb_o !== 1'b0 || cyc_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL read_rsp: rv=%0b dat=%h last=%0b err=%0b stb=%0b cyc=%0b want 1 deadbeef 1 0 0 1",
               rsp_valid, rsp_dat, rsp_last, rsp_err, stb_o, cyc_o);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    compared++;
    if (cyc_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL read_done: cyc=%0b rv=%0b crdy=%0b want 0 0 1", cyc_o, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_write_burst();
    logic [31:0] exp_adr;
    logic [31:0] wval;
    logic [2:0]  exp_cti;
    int          cyc_drops;
    cyc_drops = 0;
    issue_cmd(32'h0000_0100, 1'b1, 4'hA, 4'd3);
    for (int b = 0; b < 4; b++) begin
      wval    = 32'hA5A5_0000 + 32'(b);
      exp_adr = 32'h0000_0100 + 32'(4 * b);
      exp_cti = (b == 3) ? 3'b111 : 3'b010;
      compared++;
      if (wdat_ready !== 1'b1 || stb_o !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL wr_wdata_phase beat %0d: wrdy=%0b stb=%0b want 1 0", b, wdat_ready, stb_o);
      end
      if (b > 0 && cyc_o !== 1'b1) cyc_drops++;
      wdat_valid = 1'b1;
      wdat       = wval;
      @(negedge clk);
      wdat_valid = 1'b0;
      compared++;
      if (adr_o !== exp_adr || cti_o !== exp_cti || dat_o !== wval || we_o !== 1'b1 ||
          stb_o !== 1'b1 || sel_o !== 4'hA || bte_o !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL wr_bus beat %0d: adr=%h cti=%b dat=%h we=%0b stb=%0b sel=%h bte=%b want %h %b %h 1 1 a 00",
                 b, adr_o, cti_o, dat_o, we_o, stb_o, sel_o, bte_o, exp_adr, exp_cti, wval);
      end
      if (cyc_o !== 1'b1) cyc_drops++;
      ack_i = 1'b1;
      dat_i = 32'h1234_5678;
      @(negedge clk);
      ack_i = 1'b0;
      dat_i = 32'd0;
      compared++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'd0 ||
          rsp_last !== ((b == 3) ? 1'b1 : 1'b0)) begin
        mismatched++;
        $display("[TB] FAIL wr_rsp beat %0d: rv=%0b err=%0b dat=%h last=%0b want 1 0 0 %0b",
                 b, rsp_valid, rsp_err, rsp_dat, rsp_last, (b == 3));
      end
      if (cyc_o !== 1'b1) cyc_drops++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    compared++;
    if (cyc_drops != 0) begin
      mismatched++;
      $display("[TB] FAIL wr_cyc_continuous: drops=%0d want 0", cyc_drops);
    end
    compared++;
    if (cyc_o !== 1'b0 || cmd_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wr_done: cyc=%0b crdy=%0b want 0 1", cyc_o, cmd_ready);
    end
  endtask

  task automatic test_retry();
    int n_rty;
    int gap_bad;
    for (int c = 0; c < 2; c++) begin
      n_rty   = (c == 0) ? 3 : 4;
      gap_bad = 0;
      issue_cmd(32'h0000_0020, 1'b0, 4'hF, 4'd0);
      for (int r = 0; r < n_rty; r++) begin
        if (stb_o !== 1'b1) gap_bad++;
        rty_i = 1'b1;
        @(negedge clk);
        rty_i = 1'b0;
        if (r < 3) begin
          if (stb_o !== 1'b0 || rsp_valid !== 1'b0 || cyc_o !== 1'b1) gap_bad++;
          @(negedge clk);
        end
      end
      compared++;
      if (gap_bad != 0) begin
        mismatched++;
        $display("[TB] FAIL retry_gap case %0d: bad_cycles=%0d want 0", c, gap_bad);
      end
      if (c == 0) begin
        compared++;
        if (stb_o !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL retry_reissue: stb=%0b want 1", stb_o);
        end
        ack_i = 1'b1;
        dat_i = 32'h0BAD_F00D;
        @(negedge clk);
        ack_i = 1'b0;
        dat_i = 32'd0;
        compared++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_last !== 1'b1 || rsp_dat !== 32'h0BAD_F00D) begin
          mismatched++;
          $display("[TB] FAIL retry_ok_rsp: rv=%0b err=%0b last=%0b dat=%h want 1 0 1 0badf00d",
                   rsp_valid, rsp_err, rsp_last, rsp_dat);
        end
      end else begin
        compared++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_last !== 1'b1 || cyc_o !== 1'b0 || stb_o !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL retry_exhausted_rsp: rv=%0b err=%0b last=%0b cyc=%0b stb=%0b want 1 1 1 0 0",
                   rsp_valid, rsp_err, rsp_last, cyc_o, stb_o);
        end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      compared++;
      if (cmd_ready !== 1'b1 || cyc_o !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL retry_done case %0d: crdy=%0b cyc=%0b want 1 0", c, cmd_ready, cyc_o);
      end
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    issue_cmd(32'h0000_0040, 1'b0, 4'hF, 4'd0);
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      if (rsp_valid !== 1'b0 || stb_o !== 1'b1 || cyc_o !== 1'b1) early++;
      @(negedge clk);
    end
    compared++;
    if (early != 0) begin
      mismatched++;
      $display("[TB] FAIL timeout_wait: bad_cycles=%0d want 0", early);
    end
    compared++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_last !== 1'b1 || cyc_o !== 1'b0 || stb_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_rsp: rv=%0b err=%0b last=%0b cyc=%0b stb=%0b want 1 1 1 0 0",
               rsp_valid, rsp_err, rsp_last, cyc_o, stb_o);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL timeout_done: crdy=%0b want 1", cmd_ready);
    end
  endtask

  task automatic test_read_error();
    int stray_stb;
    stray_stb = 0;
    issue_cmd(32'h0000_0200, 1'b0, 4'hF, 4'd3);
    compared++;
    if (adr_o !== 32'h200 || cti_o !== 3'b010 || stb_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rderr_beat0_bus: adr=%h cti=%b stb=%0b want 00000200 010 1", adr_o, cti_o, stb_o);
    end
    ack_i = 1'b1;
    dat_i = 32'h1111_0000;
    @(negedge clk);
    ack_i = 1'b0;
    dat_i = 32'd0;
    compared++;
    if (rsp_valid !== 1'b1 || rsp_dat !== 32'h1111_0000 || rsp_last !== 1'b0 || rsp_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rderr_beat0_rsp: rv=%0b dat=%h last=%0b err=%0b want 1 11110000 0 0",
               rsp_valid, rsp_dat, rsp_last, rsp_err);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    compared++;
    if (adr_o !== 32'h204 || stb_o !== 1'b1 || cyc_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rderr_beat1_bus: adr=%h stb=%0b cyc=%0b want 00000204 1 1", adr_o, stb_o, cyc_o);
    end
    err_i = 1'b1;
    @(negedge clk);
    err_i = 1'b0;
    compared++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_last !== 1'b1 || cyc_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rderr_rsp: rv=%0b err=%0b last=%0b cyc=%0b want 1 1 1 0",
               rsp_valid, rsp_err, rsp_last, cyc_o);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (stb_o !== 1'b0 || cyc_o !== 1'b0 || rsp_valid !== 1'b0) stray_stb++;
      @(negedge clk);
    end
    compared++;
    if (stray_stb != 0 || cmd_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rderr_abandon: stray_cycles=%0d crdy=%0b want 0 1", stray_stb, cmd_ready);
    end
  endtask

  task automatic test_priority_wrap();
    issue_cmd(32'hFFFF_FFFF, 1'b0, 4'h3, 4'd1);
    compared++;
    if (adr_o !== 32'hFFFF_FFFC || cti_o !== 3'b010 || sel_o !== 4'h3) begin
      mismatched++;
      $display("[TB] FAIL prio_beat0_bus: adr=%h cti=%b sel=%h want fffffffc 010 3", adr_o, cti_o, sel_o);
    end
    ack_i = 1'b1;
    err_i = 1'b1;
    rty_i = 1'b1;
    dat_i = 32'hCAFE_0001;
    @(negedge clk);
    ack_i = 1'b0;
    err_i = 1'b0;
    rty_i = 1'b0;
    dat_i = 32'd0;
    compared++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'hCAFE_0001 || rsp_last !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL prio_ack_wins: rv=%0b err=%0b dat=%h last=%0b want 1 0 cafe0001 0",
               rsp_valid, rsp_err, rsp_dat, rsp_last);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    compared++;
    if (adr_o !== 32'h0000_0000 || cti_o !== 3'b111 || stb_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL prio_wrap_bus: adr=%h cti=%b stb=%0b want 00000000 111 1", adr_o, cti_o, stb_o);
    end
    err_i = 1'b1;
    rty_i = 1'b1;
    @(negedge clk);
    err_i = 1'b0;
    rty_i = 1'b0;
    compared++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_last !== 1'b1 || cyc_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL prio_err_over_rty: rv=%0b err=%0b last=%0b cyc=%0b want 1 1 1 0",
               rsp_valid, rsp_err, rsp_last, cyc_o);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midburst();
    issue_cmd(32'h0000_0300, 1'b0, 4'hF, 4'd7);
    for (int b = 0; b < 2; b++) begin
      ack_i = 1'b1;
      dat_i = 32'h5500_0000 + 32'(b);
      @(negedge clk);
      ack_i = 1'b0;
      dat_i = 32'd0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    compared++;
    if (adr_o !== 32'h308 || stb_o !== 1'b1 || cyc_o !== 1'b1 || rsp_dat !== 32'h5500_0001) begin
      mismatched++;
      $display("[TB] FAIL rstmid_beat2_bus: adr=%h stb=%0b cyc=%0b rsp=%h want 00000308 1 1 55000001",
               adr_o, stb_o, cyc_o, rsp_dat);
    end
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({cyc_o, stb_o, we_o, rsp_valid, rsp_err, rsp_last, wdat_ready, cmd_ready} !== 8'b0 ||
        adr_o !== 32'd0 || dat_o !== 32'd0 || rsp_dat !== 32'd0 || sel_o !== 4'd0 ||
        cti_o !== 3'b000 || bte_o !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL rstmid_outputs: cyc=%0b stb=%0b rv=%0b crdy=%0b adr=%h rsp=%h sel=%h cti=%b want all zero",
               cyc_o, stb_o, rsp_valid, cmd_ready, adr_o, rsp_dat, sel_o, cti_o);
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || cyc_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rstmid_release: crdy=%0b rv=%0b cyc=%0b want 1 0 0", cmd_ready, rsp_valid, cyc_o);
    end
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_adr    = 32'd0;
    cmd_we     = 1'b0;
    cmd_sel    = 4'd0;
    cmd_len    = 4'd0;
    wdat_valid = 1'b0;
    wdat       = 32'd0;
    rsp_ready  = 1'b0;
    dat_i      = 32'd0;
    ack_i      = 1'b0;
    err_i      = 1'b0;
    rty_i      = 1'b0;
    @(negedge clk);

    test_reset();
    test_single_read();
    test_write_burst();
    test_retry();
    test_timeout();
    test_read_error();
    test_priority_wrap();
    test_reset_midburst();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles in BUS without ack_i/err_i/rty_i before the beat is aborted.
REQ-002 SHALL have parameter MAX_RETRY, default 3: rty_i re-issues allowed per beat before the beat is failed.
REQ-003 clk  in  1  sole clock; every register updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-006 cmd_adr  in  32  start byte address; bits [1:0] ignored and driven 0 on adr_o.
REQ-007 cmd_we, cmd_sel, cmd_len  in  1/4/4  write flag, byte lanes, beats-1 (0..15).
REQ-008 wdat_valid/wdat_ready, wdat  in/out, in  1/1, 32  write-beat data handshake.
REQ-009 rsp_valid/rsp_ready, rsp_dat, rsp_err, rsp_last  out/in, out, out, out  1/1, 32, 1, 1  per-beat response.
REQ-010 adr_o, dat_o, sel_o, we_o, cyc_o, stb_o, cti_o, bte_o  out  32/32/4/1/1/1/3/2  Wishbone master outputs.
REQ-011 dat_i, ack_i, err_i, rty_i  in  32/1/1/1  Wishbone slave returns.

Function
REQ-012 SHALL implement FSM IDLE, WDATA, BUS, RSP.
REQ-013 IDLE: cmd_ready=1; on cmd_valid: latch adr/we/sel/len, beat=0, retry=0; go WDATA if cmd_we, else BUS.
REQ-014 WDATA: cyc_o kept at its current value, stb_o=0, wdat_ready=1; on wdat_valid: latch wdat into dat_o; go BUS.
REQ-015 BUS: cyc_o=1, stb_o=1, adr_o/sel_o/we_o/dat_o stable until termination.
REQ-016 cti_o: 000 when cmd_len=0; 010 on non-final beats; 111 on final beat. bte_o=00 always.
REQ-017 Termination priority ack_i > err_i > rty_i when several are high in one cycle.
REQ-018 ack_i: rsp_dat=dat_i for reads, 0 for writes; rsp_err=0; go RSP.
REQ-019 err_i: rsp_err=1, rsp_last=1; remaining beats abandoned; cyc_o=0 next cycle; go RSP.
REQ-020 rty_i: if retry<MAX_RETRY then retry++, stay in BUS with stb_o dropped for exactly one cycle; otherwise handle as err_i.
REQ-021 Timeout counter SHALL clear on entering BUS and on each retry; when it reaches TIMEOUT, handle as err_i.
REQ-022 RSP: rsp_valid=1, stb_o=0; rsp_last=1 on final beat or error; on rsp_ready: if rsp_last then cyc_o=0, go IDLE; else adr+=4 (wraps modulo 2^32), beat++, retry=0, go WDATA or BUS.
REQ-023 cyc_o SHALL stay high from the first BUS cycle to the final RSP handshake of a non-errored burst.
REQ-024 Minimum read-beat latency: ack_i in the first BUS cycle gives rsp_valid in the next cycle.
REQ-025 No new command SHALL be accepted until the current burst is in IDLE.

Reset
REQ-026 While rst=1 at posedge clk: state=IDLE; cyc_o, stb_o, we_o, rsp_valid, rsp_err, rsp_last, wdat_ready=0; adr_o, dat_o, rsp_dat=0; sel_o=0; cti_o=000; bte_o=00; all counters=0.
REQ-027 Reset mid-burst SHALL drop cyc_o/stb_o on the next edge and discard the burst with no response.
REQ-028 cmd_ready SHALL be 0 during reset and 1 in the first cycle after it.

Structure
REQ-029 Package wb_pkg SHALL hold CTI constants (CLASSIC=000, INCR=010, EOB=111), BTE constants (LINEAR=00) and the FSM state enum.
REQ-030 No sub-module; beat, retry and timeout counters are implemented inline.

Verification
REQ-031 Single read: cmd adr=0x10, len=0 with slave ack after 2 cycles returning 0xDEADBEEF -> cti_o=000, one rsp_dat=0xDEADBEEF with rsp_last=1, cyc_o low after handshake.
REQ-032 4-beat write burst at 0x100 -> adr_o 0x100/104/108/10C, cti_o 010,010,010,111, cyc_o continuously high, 4 responses with rsp_err=0.
REQ-033 Retry: rty_i asserted 3 times then ack -> success; rty_i asserted 4 times -> rsp_err=1, rsp_last=1.
REQ-034 Timeout: slave never responds -> rsp_err=1 exactly TIMEOUT cycles after entering BUS, cyc_o=0.
REQ-035 Error on beat 2 of 4 read -> rsp_err=1, rsp_last=1 on that beat, no further stb_o.
REQ-036 rst asserted during beat 3 of 8 -> all outputs at reset values next cycle; cmd_ready=1 in the cycle after rst drops.
